// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard controller for a classic 5-stage in-order core with a
// multi-cycle multiplier in EX. Each cycle it decides whether the front end
// advances, stalls on a data hazard, flushes behind a taken branch, or
// freezes while a MUL occupies EX. It also counts the stalled cycles.
//
// Handshake / timing: there is no valid/ready pair. All control outputs are
// combinational functions of the registered state and the current pipeline
// inputs, so they take effect at the very edge that follows the cycle in
// which the hazard is visible.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous active-low reset
//   start_i            run enable; low returns the unit to IDLE at the next edge
//   ID_RS1addr_i       rs1 of the instruction in ID
//   ID_RS2addr_i       rs2 of the instruction in ID
//   ID_uses_rs1_i      ID instruction reads rs1
//   ID_uses_rs2_i      ID instruction reads rs2
//   ID_is_branch_i     ID holds a branch
//   ID_branch_taken_i  the branch in ID resolves taken
//   EX_MemRead_i       EX instruction is a load
//   EX_RegWrite_i      EX instruction writes a register
//   EX_RDaddr_i        EX destination register
//   EX_mul_i           EX holds a MUL
//   MEM_MemRead_i      MEM instruction is a load
//   MEM_RDaddr_i       MEM destination register
//   PCWrite_o          PC update enable
//   IF_ID_write_o      IF/ID load enable
//   IF_ID_flush_o      zero IF/ID at the next edge
//   ID_EX_bubble_o     load NOP controls into ID/EX
//   EX_hold_o          hold ID/EX, insert a bubble into EX/MEM
//   stall_cnt_o        saturating count of stalled cycles
//   state_dbg_o        current FSM state (0 IDLE, 1 RUN, 2 MUL_BUSY)
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 3,   // EX occupancy of a MUL, 1..16
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] ID_RS1addr_i,
    input  logic [REG_ADDR_W-1:0] ID_RS2addr_i,
    input  logic                  ID_uses_rs1_i,
    input  logic                  ID_uses_rs2_i,
    input  logic                  ID_is_branch_i,
    input  logic                  ID_branch_taken_i,
    input  logic                  EX_MemRead_i,
    input  logic                  EX_RegWrite_i,
    input  logic [REG_ADDR_W-1:0] EX_RDaddr_i,
    input  logic                  EX_mul_i,
    input  logic                  MEM_MemRead_i,
    input  logic [REG_ADDR_W-1:0] MEM_RDaddr_i,
    output logic                  PCWrite_o,
    output logic                  IF_ID_write_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_bubble_o,
    output logic                  EX_hold_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [1:0]            state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MUL_BUSY = 2'd2
    } state_t;

    // A MUL with latency 1 finishes in its single EX cycle, so it never
    // needs the busy state. For longer latencies the entry cycle in RUN is
    // the first EX cycle and the release cycle in MUL_BUSY (mcnt==0) is the
    // last, leaving MUL_LAT-2 intermediate hold cycles for the counter.
    localparam bit         MUL_MULTI = (MUL_LAT > 1);
    localparam logic [3:0] MCNT_LOAD = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] mcnt_q;
    logic [3:0] mcnt_d;

    // -------------------------------------------------------------------------
    // Operand match: register 0 is hard-wired to zero and never a hazard.
    // -------------------------------------------------------------------------
    logic rs1_match_ex;
    logic rs2_match_ex;
    logic rs1_match_mem;
    logic rs2_match_mem;
    logic match_ex;
    logic match_mem;
    logic load_use;
    logic branch_hazard;
    logic data_stall;

    always_comb begin
        rs1_match_ex  = ID_uses_rs1_i && (ID_RS1addr_i == EX_RDaddr_i)
                        && (EX_RDaddr_i != '0);
        rs2_match_ex  = ID_uses_rs2_i && (ID_RS2addr_i == EX_RDaddr_i)
                        && (EX_RDaddr_i != '0);
        rs1_match_mem = ID_uses_rs1_i && (ID_RS1addr_i == MEM_RDaddr_i)
                        && (MEM_RDaddr_i != '0);
        rs2_match_mem = ID_uses_rs2_i && (ID_RS2addr_i == MEM_RDaddr_i)
                        && (MEM_RDaddr_i != '0);
        match_ex      = rs1_match_ex  || rs2_match_ex;
        match_mem     = rs1_match_mem || rs2_match_mem;

        load_use      = EX_MemRead_i && match_ex;
        // Branches resolve in ID, so they also need results that are still
        // in EX (any writer) or that a load in MEM has not yet returned.
        branch_hazard = ID_is_branch_i &&
                        ((EX_RegWrite_i && match_ex) || (MEM_MemRead_i && match_mem));
        data_stall    = load_use || branch_hazard;
    end

    // -------------------------------------------------------------------------
    // Front-end control when no MUL hold is in force. Stall wins over flush:
    // a branch that is still waiting for its operands has not really resolved.
    // -------------------------------------------------------------------------
    logic adv_pc_write;
    logic adv_ifid_write;
    logic adv_flush;
    logic adv_bubble;

    always_comb begin
        adv_pc_write   = !data_stall;
        adv_ifid_write = !data_stall;
        adv_flush      = !data_stall && ID_branch_taken_i;
        adv_bubble     = data_stall;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            mcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        mcnt_d         = mcnt_q;
        PCWrite_o      = 1'b0;
        IF_ID_write_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        EX_hold_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (EX_mul_i && MUL_MULTI) begin
                    // The MUL hold outranks every other condition: the whole
                    // front end freezes and the ID instruction stays put, so
                    // no bubble and no flush.
                    EX_hold_o = 1'b1;
                    state_d   = MUL_BUSY;
                    mcnt_d    = MCNT_LOAD;
                end else begin
                    PCWrite_o      = adv_pc_write;
                    IF_ID_write_o  = adv_ifid_write;
                    IF_ID_flush_o  = adv_flush;
                    ID_EX_bubble_o = adv_bubble;
                end
            end

            MUL_BUSY: begin
                if (mcnt_q != 4'd0) begin
                    EX_hold_o = 1'b1;
                    mcnt_d    = mcnt_q - 4'd1;
                end else begin
                    // Last EX cycle of the MUL. EX_mul_i still reports the
                    // same MUL and must not restart the hold; ordinary
                    // hazards against it are still honoured.
                    PCWrite_o      = adv_pc_write;
                    IF_ID_write_o  = adv_ifid_write;
                    IF_ID_flush_o  = adv_flush;
                    ID_EX_bubble_o = adv_bubble;
                    state_d        = RUN;
                end
            end

            default: begin
                state_d = IDLE;
                mcnt_d  = 4'd0;
            end
        endcase

        // Dropping the run enable aborts whatever is in progress.
        if (!start_i) begin
            state_d = IDLE;
            mcnt_d  = 4'd0;
        end

        // The state register already clears asynchronously; gating here
        // keeps the outputs quiet for the whole reset window regardless of
        // the inputs.
        if (!rst_i) begin
            PCWrite_o      = 1'b0;
            IF_ID_write_o  = 1'b0;
            IF_ID_flush_o  = 1'b0;
            ID_EX_bubble_o = 1'b0;
            EX_hold_o      = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter: any active cycle in which the PC does not move.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if ((state_q != IDLE) && !PCWrite_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_stall_unit.
// dut  : MUL_LAT=3, CNT_W=16 (main instance)
// dut1 : MUL_LAT=1, CNT_W=2  (single-cycle MUL, fast counter saturation)
// Both share every input. Control outputs are packed as
// {PCWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_hold}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam logic [4:0] C_OFF   = 5'b00000;
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11100;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  logic       start_i = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0;
  logic       uses1 = 1'b0, uses2 = 1'b0, is_br = 1'b0, taken = 1'b0;
  logic       ex_mr = 1'b0, ex_rw = 1'b0, ex_mul = 1'b0, mem_mr = 1'b0;

  logic        pcw, ifw, fl, bub, hold;
  logic [15:0] cnt;
  logic [1:0]  st;
  logic        pcw1, ifw1, fl1, bub1, hold1;
  logic [1:0]  cnt1;
  logic [1:0]  st1;
  logic [4:0]  ctrl, ctrl1;
  assign ctrl  = {pcw, ifw, fl, bub, hold};
  assign ctrl1 = {pcw1, ifw1, fl1, bub1, hold1};

  hazard_stall_unit #(.REG_ADDR_W(5), .MUL_LAT(3), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .ID_RS1addr_i(id_rs1), .ID_RS2addr_i(id_rs2),
    .ID_uses_rs1_i(uses1), .ID_uses_rs2_i(uses2),
    .ID_is_branch_i(is_br), .ID_branch_taken_i(taken),
    .EX_MemRead_i(ex_mr), .EX_RegWrite_i(ex_rw), .EX_RDaddr_i(ex_rd),
    .EX_mul_i(ex_mul), .MEM_MemRead_i(mem_mr), .MEM_RDaddr_i(mem_rd),
    .PCWrite_o(pcw), .IF_ID_write_o(ifw), .IF_ID_flush_o(fl),
    .ID_EX_bubble_o(bub), .EX_hold_o(hold), .stall_cnt_o(cnt),
    .state_dbg_o(st)
  );

  hazard_stall_unit #(.REG_ADDR_W(5), .MUL_LAT(1), .CNT_W(2)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .ID_RS1addr_i(id_rs1), .ID_RS2addr_i(id_rs2),
    .ID_uses_rs1_i(uses1), .ID_uses_rs2_i(uses2),
    .ID_is_branch_i(is_br), .ID_branch_taken_i(taken),
    .EX_MemRead_i(ex_mr), .EX_RegWrite_i(ex_rw), .EX_RDaddr_i(ex_rd),
    .EX_mul_i(ex_mul), .MEM_MemRead_i(mem_mr), .MEM_RDaddr_i(mem_rd),
    .PCWrite_o(pcw1), .IF_ID_write_o(ifw1), .IF_ID_flush_o(fl1),
    .ID_EX_bubble_o(bub1), .EX_hold_o(hold1), .stall_cnt_o(cnt1),
    .state_dbg_o(st1)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  exp1_q[$];
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_cnt1 = '0;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
    uses1 = 1'b0; uses2 = 1'b0; is_br = 1'b0; taken = 1'b0;
    ex_mr = 1'b0; ex_rw = 1'b0; ex_mul = 1'b0; mem_mr = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] rs, input logic on_rs2);
    clear_inputs();
    ex_mr = 1'b1; ex_rw = 1'b1; ex_rd = rd;
    if (on_rs2) begin id_rs2 = rs; uses2 = 1'b1; end
    else begin id_rs1 = rs; uses1 = 1'b1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] e;
    repeat (2) @(negedge clk);
    exp_q.push_back(C_OFF);
    #2;
    e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, e); end
    tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    tests++; if (st !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", st, S_IDLE); end
    @(negedge clk); rst_i = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(C_OFF);
    #2;
    e = exp_q.pop_front();
    tests++; if (st !== S_IDLE || ctrl !== e) begin fails++; $display("FAIL idle_hold: state %0d ctrl %b expected state 0 ctrl %b", st, ctrl, e); end
  endtask

  task automatic test_start();
    logic [4:0] e;
    @(negedge clk); start_i = 1'b1; clear_inputs();
    exp_q.push_back(C_OFF);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e || st !== S_IDLE) begin fails++; $display("FAIL start_idle: ctrl %b state %0d expected %b state 0", ctrl, st, e); end
    @(negedge clk);
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e || st !== S_RUN) begin fails++; $display("FAIL start_run: ctrl %b state %0d expected %b state 1", ctrl, st, e); end
  endtask

  task automatic test_load_use();
    logic [4:0] e;
    logic [4:0] r;
    @(negedge clk); drive_load_use(5'd5, 5'd5, 1'b0);
    exp_q.push_back(C_STALL);
    #2; e = exp_q.pop_front();
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL lu_cnt_before: got %0d expected %0d", cnt, exp_cnt); end
    tests++; if (ctrl !== e) begin fails++; $display("FAIL lu_ctrl: got %b expected %b", ctrl, e); end
    exp_cnt++;
    @(negedge clk); clear_inputs();
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL lu_cnt_after: got %0d expected %0d", cnt, exp_cnt); end
    tests++; if (ctrl !== e) begin fails++; $display("FAIL lu_release: got %b expected %b", ctrl, e); end
    // random nonzero registers on rs2: match stalls, neighbour does not
    for (int i = 0; i < 4; i++) begin
      r = 5'($urandom_range(2, 31));
      @(negedge clk); drive_load_use(r, r, 1'b1);
      exp_q.push_back(C_STALL);
      #2; e = exp_q.pop_front();
      tests++; if (ctrl !== e) begin fails++; $display("FAIL lu_rand_match r=%0d: got %b expected %b", r, ctrl, e); end
      exp_cnt++;
      @(negedge clk); drive_load_use(r, r ^ 5'd1, 1'b1);
      exp_q.push_back(C_RUN);
      #2; e = exp_q.pop_front();
      tests++; if (ctrl !== e) begin fails++; $display("FAIL lu_rand_miss r=%0d: got %b expected %b", r, ctrl, e); end
    end
    // address matches but the operand is not read
    @(negedge clk); drive_load_use(5'd9, 5'd9, 1'b1); uses2 = 1'b0;
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL lu_unused_operand: got %b expected %b", ctrl, e); end
    @(negedge clk); clear_inputs();
    #2;
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL lu_cnt_total: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_x0();
    logic [4:0] e;
    @(negedge clk); drive_load_use(5'd0, 5'd0, 1'b0);
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL x0_exempt: got %b expected %b", ctrl, e); end
    @(negedge clk); clear_inputs();
    #2;
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL x0_cnt: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_branch();
    logic [4:0] e;
    @(negedge clk); clear_inputs(); is_br = 1'b1; taken = 1'b1;
    exp_q.push_back(C_FLUSH);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL br_flush: got %b expected %b", ctrl, e); end
    @(negedge clk); clear_inputs();
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL br_flush_one_cycle: got %b expected %b", ctrl, e); end
    @(negedge clk); clear_inputs(); is_br = 1'b1; taken = 1'b1;
    ex_rw = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; uses2 = 1'b1;
    exp_q.push_back(C_STALL);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL br_ex_stall: got %b expected %b", ctrl, e); end
    exp_cnt++;
    @(negedge clk); clear_inputs(); is_br = 1'b1;
    mem_mr = 1'b1; mem_rd = 5'd9; id_rs1 = 5'd9; uses1 = 1'b1;
    exp_q.push_back(C_STALL);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL br_mem_stall: got %b expected %b", ctrl, e); end
    exp_cnt++;
    // an ALU result in EX is forwarded for ordinary instructions
    @(negedge clk); clear_inputs();
    ex_rw = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; uses2 = 1'b1;
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL nonbranch_no_stall: got %b expected %b", ctrl, e); end
    @(negedge clk); clear_inputs();
    #2;
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL br_cnt: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_mul();
    logic [4:0] e;
    logic [4:0] e1;
    logic [15:0] base;
    base = exp_cnt;
    @(negedge clk); clear_inputs(); ex_mul = 1'b1;
    exp_q.push_back(C_HOLD); exp1_q.push_back(C_RUN);
    #2; e = exp_q.pop_front(); e1 = exp1_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL mul_enter: got %b expected %b", ctrl, e); end
    tests++; if (ctrl1 !== e1) begin fails++; $display("FAIL mul1_enter: got %b expected %b", ctrl1, e1); end
    @(negedge clk);
    exp_q.push_back(C_HOLD); exp1_q.push_back(C_RUN);
    #2; e = exp_q.pop_front(); e1 = exp1_q.pop_front();
    tests++; if (ctrl !== e || st !== S_BUSY) begin fails++; $display("FAIL mul_busy: ctrl %b state %0d expected %b state 2", ctrl, st, e); end
    tests++; if (ctrl1 !== e1 || st1 !== S_RUN) begin fails++; $display("FAIL mul1_busy: ctrl %b state %0d expected %b state 1", ctrl1, st1, e1); end
    @(negedge clk);
    exp_q.push_back(C_RUN); exp1_q.push_back(C_RUN);
    #2; e = exp_q.pop_front(); e1 = exp1_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL mul_release: got %b expected %b", ctrl, e); end
    tests++; if (ctrl1 !== e1) begin fails++; $display("FAIL mul1_release: got %b expected %b", ctrl1, e1); end
    @(negedge clk); clear_inputs();
    exp_cnt = base + 16'd2;
    #2;
    tests++; if (st !== S_RUN || cnt !== exp_cnt) begin fails++; $display("FAIL mul_done: state %0d cnt %0d expected state 1 cnt %0d", st, cnt, exp_cnt); end
  endtask

  task automatic test_simultaneous();
    logic [4:0] e;
    logic [4:0] e1;
    @(negedge clk); drive_load_use(5'd5, 5'd5, 1'b0);
    ex_mul = 1'b1; is_br = 1'b1; taken = 1'b1;
    exp_q.push_back(C_HOLD); exp1_q.push_back(C_STALL);
    #2; e = exp_q.pop_front(); e1 = exp1_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL simul_priority: got %b expected %b", ctrl, e); end
    tests++; if (ctrl1 !== e1) begin fails++; $display("FAIL simul_mul1_stall: got %b expected %b", ctrl1, e1); end
    @(negedge clk); clear_inputs();
    exp_q.push_back(C_HOLD);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL simul_hold2: got %b expected %b", ctrl, e); end
    @(negedge clk);
    exp_q.push_back(C_RUN);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e) begin fails++; $display("FAIL simul_release: got %b expected %b", ctrl, e); end
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clk);
    #2;
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL simul_cnt: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_abort_reset();
    logic [4:0] e;
    @(negedge clk); clear_inputs(); ex_mul = 1'b1;
    @(negedge clk); clear_inputs();
    exp_q.push_back(C_OFF);
    #1;
    tests++; if (st !== S_BUSY || ctrl !== C_HOLD) begin fails++; $display("FAIL abort_pre: state %0d ctrl %b expected state 2 ctrl %b", st, ctrl, C_HOLD); end
    #1 rst_i = 1'b0;
    #1; e = exp_q.pop_front();
    exp_cnt = '0; exp_cnt1 = '0;
    tests++; if (ctrl !== e || cnt !== exp_cnt || st !== S_IDLE) begin fails++; $display("FAIL async_reset: ctrl %b cnt %0d state %0d expected %b 0 0", ctrl, cnt, st, e); end
    tests++; if (ctrl1 !== e || cnt1 !== exp_cnt1) begin fails++; $display("FAIL async_reset1: ctrl %b cnt %0d expected %b 0", ctrl1, cnt1, e); end
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk);
    #2;
    tests++; if (st !== S_RUN) begin fails++; $display("FAIL reenter_run: got %0d expected %0d", st, S_RUN); end
    ex_mul = 1'b1;
    exp_cnt++;
    @(negedge clk); clear_inputs(); start_i = 1'b0;
    exp_q.push_back(C_HOLD);
    #2; e = exp_q.pop_front();
    tests++; if (ctrl !== e || st !== S_BUSY) begin fails++; $display("FAIL abort_busy: ctrl %b state %0d expected %b state 2", ctrl, st, e); end
    exp_cnt++;
    @(negedge clk);
    exp_q.push_back(C_OFF);
    #2; e = exp_q.pop_front();
    tests++; if (st !== S_IDLE || ctrl !== e || cnt !== exp_cnt) begin fails++; $display("FAIL abort_idle: state %0d ctrl %b cnt %0d expected state 0 ctrl %b cnt %0d", st, ctrl, cnt, e, exp_cnt); end
  endtask

  task automatic test_saturation();
    @(negedge clk); rst_i = 1'b0; clear_inputs();
    exp_cnt = '0; exp_cnt1 = '0;
    @(negedge clk); rst_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      drive_load_use(5'd12, 5'd12, 1'b1);
      @(negedge clk);
      exp_cnt++;
      exp_cnt1 = (exp_cnt1 == 2'd3) ? 2'd3 : exp_cnt1 + 2'd1;
      #2;
      tests++; if (cnt1 !== exp_cnt1) begin fails++; $display("FAIL sat_cnt1 step %0d: got %0d expected %0d", k, cnt1, exp_cnt1); end
    end
    clear_inputs();
    tests++; if (cnt !== exp_cnt) begin fails++; $display("FAIL sat_cnt_wide: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_load_use();
    test_x0();
    test_branch();
    test_mul();
    test_simultaneous();
    test_abort_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
